// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS layout and serializer state encodings.
package uart_pkg;

    localparam int unsigned BAUD_W    = 16;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned STATE_W   = 2;

    // Word offsets decoded from addr[3:2]
    localparam logic [1:0] ADDR_TXDATA  = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_BAUDDIV = 2'd2;
    localparam logic [1:0] ADDR_RSVD    = 2'd3;

    localparam int unsigned ST_FULL_BIT  = 0;
    localparam int unsigned ST_EMPTY_BIT = 1;
    localparam int unsigned ST_BUSY_BIT  = 2;
    localparam int unsigned ST_OVF_BIT   = 3;
    localparam int unsigned ST_CNT_LSB   = 4;
    localparam int unsigned ST_CNT_W     = 4;

    // Serializer states
    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_START = 2'd1;
    localparam logic [STATE_W-1:0] S_DATA  = 2'd2;
    localparam logic [STATE_W-1:0] S_STOP  = 2'd3;

    // STATUS payload, LSB first matches the bit positions above
    typedef struct packed {
        logic [ST_CNT_W-1:0] count;
        logic                ovf;
        logic                busy;
        logic                empty;
        logic                full;
    } status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; push and pop may both
// succeed in one cycle even when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers, a TX
// FIFO and a bit-serializer with a per-frame latched baud divider.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned      DW           = 32,
    parameter int unsigned      FIFO_DEPTH   = 4,
    parameter logic [15:0]      BAUD_DIV_RST = 16'd867
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cs,
    input  logic          we,
    input  logic [3:0]    mask,
    input  logic [DW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          tx_o
);

    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]             sel;
    logic                   wr_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   ovf_set_c;
    logic                   ovf_clr_c;
    logic                   baud_wr_c;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_CNT_W-1:0]  fifo_count;

    logic                   ovf;
    logic [BAUD_W-1:0]      bauddiv;
    status_t                status;

    logic [STATE_W-1:0]     state,   state_d;
    logic [BAUD_W-1:0]      cnt,     cnt_d;
    logic [BAUD_W-1:0]      div,     div_d;
    logic [IDX_W-1:0]       idx,     idx_d;
    logic [DATA_BITS-1:0]   shreg,   shreg_d;
    logic                   tx_d;
    logic                   bit_end;
    logic                   unused_bits;

    assign sel       = addr_i[3:2];
    assign wr_c      = !cs && we;
    assign push_c    = wr_c && (sel == ADDR_TXDATA) && mask[0];
    assign ovf_set_c = push_c && fifo_full && !pop_c;
    assign ovf_clr_c = wr_c && (sel == ADDR_STATUS) && mask[0] && wdata_i[ST_OVF_BIT];
    assign baud_wr_c = wr_c && (sel == ADDR_BAUDDIV);

    assign unused_bits = ^{addr_i[DW-1:4], addr_i[1:0], wdata_i[DW-1:16], mask[3:2]};

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push_c),
        .pop   (pop_c),
        .din   (wdata_i[DATA_BITS-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register file: sticky overflow (set beats clear) and byte-lane BAUDDIV
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf     <= 1'b0;
            bauddiv <= BAUD_DIV_RST;
        end else begin
            ovf <= ovf_set_c || (ovf && !ovf_clr_c);
            if (baud_wr_c && mask[0]) begin
                bauddiv[7:0] <= wdata_i[7:0];
            end
            if (baud_wr_c && mask[1]) begin
                bauddiv[15:8] <= wdata_i[15:8];
            end
        end
    end

    always_comb begin
        status       = '0;
        status.full  = fifo_full;
        status.empty = fifo_empty;
        status.busy  = (state != S_IDLE);
        status.ovf   = ovf;
        status.count = ST_CNT_W'(fifo_count);
    end

    always_comb begin
        rdata_o = '0;
        case (sel)
            ADDR_STATUS:  rdata_o = DW'(status);
            ADDR_BAUDDIV: rdata_o = DW'(bauddiv);
            default:      rdata_o = '0;
        endcase
    end

    assign bit_end = (cnt == div);

    // Serializer next state; a frame is loaded from IDLE or straight out of STOP
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        div_d   = div;
        idx_d   = idx;
        shreg_d = shreg;
        pop_c   = 1'b0;
        tx_d    = 1'b1;

        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shreg_d = fifo_dout;
                    div_d   = bauddiv;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        shreg_d = shreg >> 1;
                    end
                end else begin
                    cnt_d = cnt + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shreg_d = fifo_dout;
                        div_d   = bauddiv;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt + BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cnt   <= '0;
            div   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx_o  <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            div   <= div_d;
            idx   <= idx_d;
            shreg <= shreg_d;
            tx_o  <= tx_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: expected frames are queued on each
// accepted TXDATA write and checked sample-by-sample by a line monitor.
module tb_mmio_uart_tx;

    localparam logic [31:0] A_TX = 32'h0;
    localparam logic [31:0] A_ST = 32'h4;
    localparam logic [31:0] A_BD = 32'h8;
    localparam logic [31:0] A_RS = 32'hC;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    logic        clk_i;
    logic        rst_i;
    logic        cs;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        tx_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   gaps[$];
    bit   mon_en = 1'b1;
    bit   mon_busy = 1'b0;
    time  t_end = 0;

    mmio_uart_tx #(
        .DW           (32),
        .FIFO_DEPTH   (4),
        .BAUD_DIV_RST (16'd867)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cs      (cs),
        .we      (we),
        .mask    (mask),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .tx_o    (tx_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Line monitor: every negedge of a frame must match start/data/stop
    initial begin
        exp_t       e;
        logic [9:0] wave;
        int         p;
        int         bad;
        bit         ok;
        time        t_start;
        forever begin
            @(negedge clk_i);
            if (mon_en && !rst_i && tx_o === 1'b0) begin
                mon_busy = 1'b1;
                t_start  = $time;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: start bit at %0t, required none", $time);
                    while (tx_o === 1'b0 && !rst_i) @(negedge clk_i);
                end else begin
                    e    = sb.pop_front();
                    p    = e.div + 1;
                    wave = {1'b1, e.data, 1'b0};
                    ok   = 1'b1;
                    bad  = -1;
                    for (int b = 0; b < 10; b++) begin
                        for (int c = 0; c < p; c++) begin
                            if (b != 0 || c != 0) @(negedge clk_i);
                            if (tx_o !== wave[b] && ok) begin
                                ok  = 1'b0;
                                bad = b;
                            end
                        end
                    end
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL frame 0x%02h div %0d: tx_o wrong in slot %0d, required %b",
                                 e.data, e.div, bad, wave[bad]);
                    end
                    gaps.push_back(int'((t_start - t_end) / 10));
                    t_end = $time;
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr_i  = a;
        wdata_i = d;
        mask    = m;
        cs      = 1'b0;
        we      = 1'b1;
        @(posedge clk_i);
        #1;
        cs   = 1'b1;
        we   = 1'b0;
        mask = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr_i = a;
        cs     = 1'b0;
        we     = 1'b0;
        #1;
        d  = rdata_o;
        cs = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] s;
        int          n;
        bit          done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(posedge clk_i);
            #1;
            bus_read(A_ST, s);
            if (sb.size() == 0 && s[2] == 1'b0 && !mon_busy) done = 1'b1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle: not idle after %0d cycles (queue %0d, status 0x%02h), required idle",
                     n, sb.size(), s[7:0]);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst_i = 1'b0;
        #1 rst_i = 1'b1;
        #2;
        checks++;
        if (tx_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b, required 1", tx_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h2) begin
            errors++;
            $display("FAIL reset_status: got 0x%08h, required 0x00000002", r);
        end
        bus_read(A_BD, r);
        checks++;
        if (r !== 32'd867) begin
            errors++;
            $display("FAIL reset_bauddiv: got %0d, required 867", r);
        end
        bus_read(A_RS, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL reset_reserved: got 0x%08h, required 0", r);
        end
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        bus_read(A_TX, r);
        checks++;
        if (r !== 32'h0 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: txdata read 0x%08h tx %b, required 0 and 1", r, tx_o);
        end
    endtask

    task automatic test_basic();
        logic [31:0] r;
        bus_write(A_BD, 32'd3, 4'b0011);
        bus_read(A_BD, r);
        checks++;
        if (r !== 32'd3) begin
            errors++;
            $display("FAIL basic_bauddiv: got %0d, required 3", r);
        end
        sb.push_back('{data: 8'hA5, div: 3});
        bus_write(A_TX, 32'hA5, 4'b0001);
        checks++;
        if (tx_o !== 1'b1) begin
            errors++;
            $display("FAIL latency_k: tx %b after write edge, required 1", tx_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (tx_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_k1: tx %b one edge after write, required 0", tx_o);
        end
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h06) begin
            errors++;
            $display("FAIL basic_status_busy: got 0x%02h, required 0x06", r);
        end
        wait_idle(200);
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h02) begin
            errors++;
            $display("FAIL basic_status_idle: got 0x%02h, required 0x02", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [7:0]  d;
        bus_write(A_BD, 32'd0, 4'b0011);
        gaps.delete();
        for (int i = 0; i < 5; i++) begin
            d = 8'(8'h11 * (i + 1));
            sb.push_back('{data: d, div: 0});
            bus_write(A_TX, 32'(d), 4'b0001);
        end
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h45) begin
            errors++;
            $display("FAIL b2b_status: got 0x%02h, required 0x45", r);
        end
        wait_idle(500);
        checks++;
        if (gaps.size() != 5) begin
            errors++;
            $display("FAIL b2b_frames: got %0d frames, required 5", gaps.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (gaps[i] != 1) begin
                    errors++;
                    $display("FAIL b2b_gap%0d: start %0d cycles after stop, required 1", i, gaps[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        bus_write(A_BD, 32'd100, 4'b0011);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sb.push_back('{data: 8'(8'hC0 + i), div: 100});
            bus_write(A_TX, 32'(8'hC0 + i), 4'b0001);
        end
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h4D) begin
            errors++;
            $display("FAIL ovf_status: got 0x%02h, required 0x4D", r);
        end
        bus_write(A_ST, 32'h8, 4'b0001);
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h45) begin
            errors++;
            $display("FAIL ovf_clear: got 0x%02h, required 0x45", r);
        end
        wait_idle(6000);
    endtask

    task automatic test_mask();
        logic [31:0] r;
        bus_write(A_TX, 32'h3C, 4'b1110);
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h02) begin
            errors++;
            $display("FAIL mask_status: got 0x%02h, required 0x02", r);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (tx_o !== 1'b1) begin
                errors++;
                $display("FAIL mask_tx%0d: got %b, required 1", i, tx_o);
            end
        end
    endtask

    task automatic test_baud_change();
        logic [31:0] r;
        bus_write(A_BD, 32'd3, 4'b0011);
        sb.push_back('{data: 8'h5C, div: 3});
        sb.push_back('{data: 8'h93, div: 10});
        bus_write(A_TX, 32'h5C, 4'b0001);
        bus_write(A_TX, 32'h93, 4'b0001);
        repeat (10) @(posedge clk_i);
        #1;
        bus_write(A_BD, 32'd10, 4'b0011);
        bus_read(A_BD, r);
        checks++;
        if (r !== 32'd10) begin
            errors++;
            $display("FAIL baud_change_read: got %0d, required 10", r);
        end
        wait_idle(1000);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        mon_en = 1'b0;
        bus_write(A_BD, 32'd3, 4'b0011);
        bus_write(A_TX, 32'hA5, 4'b0001);
        repeat (18) @(posedge clk_i);
        #3;
        checks++;
        if (tx_o !== 1'b0) begin
            errors++;
            $display("FAIL midframe_bit3: got %b, required 0", tx_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (tx_o !== 1'b1) begin
            errors++;
            $display("FAIL midframe_async: got %b, required 1", tx_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h02) begin
            errors++;
            $display("FAIL midframe_status: got 0x%02h, required 0x02", r);
        end
        bus_read(A_BD, r);
        checks++;
        if (r !== 32'd867) begin
            errors++;
            $display("FAIL midframe_bauddiv: got %0d, required 867", r);
        end
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (tx_o !== 1'b1) begin
            errors++;
            $display("FAIL midframe_idle: got %b, required 1", tx_o);
        end
    endtask

    initial begin
        cs      = 1'b1;
        we      = 1'b0;
        mask    = 4'b0000;
        addr_i  = '0;
        wdata_i = '0;
        rst_i   = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_mask();
        test_baud_change();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
